sgdmac_rd_mux: RTL and testbench

- Parametrised N-master AXI3 read-path multiplexer for the SGDMAC. It generalises the fixed two-master AR arbiter plus rid-indexed rready mux.
- Round-robin arbitration over N_MASTER read masters, e.g. descriptor fetcher and several data readers.
- Tags each burst with arid = master index and routes R beats back by rid.
- Tracks outstanding bursts per master and caps them at MAX_OUTSTANDING.

---
 rtl/sgdmac_rd_mux.sv | 217 +++++++++++++++++++++
 tb/tb_sgdmac_rd_mux.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdmac_rd_mux.sv
// SGDMAC read-path multiplexer: round-robin AR arbitration over N_MASTER read
// masters, arid = master index, R beats routed back by rid, and a cap on the
// number of outstanding bursts per master.
module sgdmac_rd_mux #(
  parameter int unsigned N_MASTER        = 4,
  parameter int unsigned ID_W            = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTER-1:0]        m_arvalid_i,
  output logic [N_MASTER-1:0]        m_arready_o,
  input  logic [N_MASTER*ADDR_W-1:0] m_araddr_i,
  input  logic [N_MASTER*4-1:0]      m_arlen_i,
  input  logic [N_MASTER*3-1:0]      m_arsize_i,
  input  logic [N_MASTER*2-1:0]      m_arburst_i,
  output logic [ID_W-1:0]            arid_o,
  output logic [ADDR_W-1:0]          araddr_o,
  output logic [3:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  input  logic [ID_W-1:0]            rid_i,
  input  logic [DATA_W-1:0]          rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic                       rvalid_i,
  output logic                       rready_o,
  output logic [N_MASTER-1:0]        m_rvalid_o,
  input  logic [N_MASTER-1:0]        m_rready_i,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic [1:0]                 m_rresp_o,
  output logic                       m_rlast_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int unsigned IdxW = $clog2(N_MASTER);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxOut  = CntW'(MAX_OUTSTANDING);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_MASTER - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               r_state;
  logic [IdxW-1:0]      r_last_grant;
  logic [ID_W-1:0]      r_arid;
  logic [ADDR_W-1:0]    r_araddr;
  logic [3:0]           r_arlen;
  logic [2:0]           r_arsize;
  logic [1:0]           r_arburst;
  logic                 r_arvalid;
  logic                 r_err;
  logic [CntW-1:0]      r_cnt [N_MASTER];

  logic [N_MASTER-1:0]  w_elig;
  logic                 w_grant_vld;
  logic [IdxW-1:0]      w_grant_idx;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [3:0]           w_sel_len;
  logic [2:0]           w_sel_size;
  logic [1:0]           w_sel_burst;
  logic                 w_rid_ok;
  logic                 w_rready_sel;
  logic                 w_done;
  logic [N_MASTER-1:0]  w_dec;
  logic                 w_zero_dec;
  logic                 w_all_zero;

  // Eligibility: requesting and below the outstanding cap.
  always_comb begin
    w_elig     = '0;
    w_all_zero = 1'b1;
    for (int k = 0; k < N_MASTER; k++) begin
      w_elig[k] = m_arvalid_i[k] && (r_cnt[k] < MaxOut);
      if (r_cnt[k] != '0) w_all_zero = 1'b0;
    end
  end

  // Round-robin search starting one past the previous grant.
  always_comb begin
    int unsigned idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= N_MASTER; i++) begin
      idx = (32'(r_last_grant) + i) % N_MASTER;
      for (int unsigned k = 0; k < N_MASTER; k++) begin
        if (!w_grant_vld && (idx == k) && w_elig[k]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = IdxW'(k);
        end
      end
    end
  end

  // Payload select for the winner and the accept pulse back to it.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_size  = '0;
    w_sel_burst = '0;
    m_arready_o = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (w_grant_idx == IdxW'(k)) begin
        w_sel_addr     = m_araddr_i[k*ADDR_W +: ADDR_W];
        w_sel_len      = m_arlen_i[k*4 +: 4];
        w_sel_size     = m_arsize_i[k*3 +: 3];
        w_sel_burst    = m_arburst_i[k*2 +: 2];
        m_arready_o[k] = (r_state == StIdle) && w_grant_vld;
      end
    end
  end

  // R routing by rid; an unknown rid matches no master and is sunk.
  always_comb begin
    w_rid_ok     = 1'b0;
    w_rready_sel = 1'b1;
    m_rvalid_o   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (rid_i == ID_W'(k)) begin
        w_rid_ok      = 1'b1;
        w_rready_sel  = m_rready_i[k];
        m_rvalid_o[k] = rvalid_i;
      end
    end
  end

  assign rready_o  = w_rready_sel;
  assign w_done    = rvalid_i && w_rid_ok && rlast_i && w_rready_sel;
  assign m_rdata_o = rdata_i;
  assign m_rresp_o = rresp_i;
  assign m_rlast_o = rlast_i;

  // Per-master completion strobe and detection of a completion with nothing outstanding.
  always_comb begin
    w_dec      = '0;
    w_zero_dec = 1'b0;
    for (int k = 0; k < N_MASTER; k++) begin
      w_dec[k] = w_done && m_rvalid_o[k];
      if (w_dec[k] && (r_cnt[k] == '0)) w_zero_dec = 1'b1;
    end
  end

  // AR FSM with registered payload and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_last_grant <= LastIdx;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_arvalid    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_vld) begin
            r_arid       <= ID_W'(w_grant_idx);
            r_araddr     <= w_sel_addr;
            r_arlen      <= w_sel_len;
            r_arsize     <= w_sel_size;
            r_arburst    <= w_sel_burst;
            r_arvalid    <= 1'b1;
            r_last_grant <= w_grant_idx;
            r_state      <= StBusy;
          end
        end
        StBusy: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outstanding counters; simultaneous accept and completion cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_MASTER; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_MASTER; k++) begin
        if (m_arready_o[k] && !w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] + CntW'(1);
        end else if (w_dec[k] && !m_arready_o[k] && (r_cnt[k] != '0)) begin
          r_cnt[k] <= r_cnt[k] - CntW'(1);
        end
      end
    end
  end

  // Sticky error: beat with unknown rid, or completion with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((rvalid_i && !w_rid_ok) || w_zero_dec) begin
      r_err <= 1'b1;
    end
  end

  assign arid_o    = r_arid;
  assign araddr_o  = r_araddr;
  assign arlen_o   = r_arlen;
  assign arsize_o  = r_arsize;
  assign arburst_o = r_arburst;
  assign arvalid_o = r_arvalid;
  assign err_o     = r_err;
  assign idle_o    = w_all_zero && !r_arvalid;

endmodule

// File: tb/tb_sgdmac_rd_mux.sv
// Bench for sgdmac_rd_mux: expected AR transactions are queued as stimulus is
// issued and a negedge monitor pops them on each downstream AR handshake.
module tb_sgdmac_rd_mux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_arvalid_i;
  logic [N-1:0]    m_arready_o;
  logic [N*AW-1:0] m_araddr_i;
  logic [N*4-1:0]  m_arlen_i;
  logic [N*3-1:0]  m_arsize_i;
  logic [N*2-1:0]  m_arburst_i;
  logic [3:0]      arid_o;
  logic [AW-1:0]   araddr_o;
  logic [3:0]      arlen_o;
  logic [2:0]      arsize_o;
  logic [1:0]      arburst_o;
  logic            arvalid_o;
  logic            arready_i;
  logic [3:0]      rid_i;
  logic [DW-1:0]   rdata_i;
  logic [1:0]      rresp_i;
  logic            rlast_i;
  logic            rvalid_i;
  logic            rready_o;
  logic [N-1:0]    m_rvalid_o;
  logic [N-1:0]    m_rready_i;
  logic [DW-1:0]   m_rdata_o;
  logic [1:0]      m_rresp_o;
  logic            m_rlast_o;
  logic            idle_o;
  logic            err_o;

  always #5 clk = ~clk;

  sgdmac_rd_mux #(
    .N_MASTER       (N),
    .ID_W           (4),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_arvalid_i(m_arvalid_i),
    .m_arready_o(m_arready_o),
    .m_araddr_i (m_araddr_i),
    .m_arlen_i  (m_arlen_i),
    .m_arsize_i (m_arsize_i),
    .m_arburst_i(m_arburst_i),
    .arid_o     (arid_o),
    .araddr_o   (araddr_o),
    .arlen_o    (arlen_o),
    .arsize_o   (arsize_o),
    .arburst_o  (arburst_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .rid_i      (rid_i),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rlast_i    (rlast_i),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rready_i (m_rready_i),
    .m_rdata_o  (m_rdata_o),
    .m_rresp_o  (m_rresp_o),
    .m_rlast_o  (m_rlast_o),
    .idle_o     (idle_o),
    .err_o      (err_o)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [44:0] exp_q [$];
  logic [44:0] mon_e;
  int          pend [N];
  logic [3:0]  exp_ack [10] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};

  function automatic logic [31:0] f_addr(int k);
    return 32'hA000_0000 + 32'(k) * 32'h104;
  endfunction

  function automatic logic [44:0] f_ar(int k);
    return {4'(k), f_addr(k), 4'(k + 3), 3'(k + 1), 2'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream AR handshake must match the next queued entry.
  always @(negedge clk) begin
    if (!rst && arvalid_o && arready_i) begin
      chk("ar_expected_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("ar_payload", {19'b0, arid_o, araddr_o, arlen_o, arsize_o, arburst_o}, {19'b0, mon_e});
      end
    end
  end

  task automatic drive_ar();
    for (int k = 0; k < N; k++) m_arvalid_i[k] = (pend[k] > 0);
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock; masters drop a request once its accept pulse is seen.
  task automatic step();
    logic [N-1:0] ack;
    logic         rst_s;
    #1;
    ack   = m_arready_o;
    rst_s = rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (!rst_s && ack[k] && pend[k] > 0) pend[k]--;
    drive_ar();
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    for (int k = 0; k < N; k++) pend[k] = 0;
    drive_ar();
    arready_i  = 1'b0;
    rid_i      = '0;
    rdata_i    = '0;
    rresp_i    = '0;
    rlast_i    = 1'b0;
    rvalid_i   = 1'b0;
    m_rready_i = '0;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("ar_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      m_araddr_i[k*AW +: AW] = f_addr(k);
      m_arlen_i[k*4 +: 4]    = 4'(k + 3);
      m_arsize_i[k*3 +: 3]   = 3'(k + 1);
      m_arburst_i[k*2 +: 2]  = 2'(k);
    end

    // Reset state
    do_reset();
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_err", err_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_arid", arid_o, 0);
    chk("rst_arready", m_arready_o, 0);

    // Masters 0 and 2 together: 0 first, then 2
    pend[0] = 1; pend[2] = 1; arready_i = 1'b1;
    exp_q.push_back(f_ar(0)); exp_q.push_back(f_ar(2));
    drive_ar(); settle();
    chk("t1_ack0", m_arready_o, 4'b0001);
    chk("t1_arvalid_pre", arvalid_o, 0);
    step();
    chk("t1_arvalid_lat", arvalid_o, 1);
    chk("t1_arid0", arid_o, 0);
    chk("t1_busy_noack", m_arready_o, 0);
    step();
    chk("t1_ack2", m_arready_o, 4'b0100);
    step();
    chk("t1_arid2", arid_o, 2);
    drain();

    // All four masters continuously: grants 0,1,2,3,0 every other cycle
    do_reset();
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1; arready_i = 1'b1;
    exp_q.push_back(f_ar(0)); exp_q.push_back(f_ar(1)); exp_q.push_back(f_ar(2));
    exp_q.push_back(f_ar(3)); exp_q.push_back(f_ar(0));
    drive_ar(); settle();
    for (int i = 0; i < 10; i++) begin
      chk("t2_rr_ack", m_arready_o, exp_ack[i]);
      step();
    end
    drain();

    // Outstanding cap on master 1, released by one completed burst
    do_reset();
    pend[1] = 5; arready_i = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(f_ar(1));
    drive_ar(); settle();
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_cap_block", m_arready_o, 0);
      step();
    end
    chk("t3_pending", pend[1], 1);
    rid_i = 4'd1; rvalid_i = 1'b1; rlast_i = 1'b1; m_rready_i = 4'b0010;
    rdata_i = 32'hDEAD_0001; rresp_i = 2'b10;
    settle();
    chk("t3_rready", rready_o, 1);
    chk("t3_rvalid", m_rvalid_o, 4'b0010);
    chk("t3_rdata", m_rdata_o, 32'hDEAD_0001);
    chk("t3_rresp", m_rresp_o, 2'b10);
    chk("t3_rlast", m_rlast_o, 1);
    exp_q.push_back(f_ar(1));
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0; m_rready_i = '0;
    settle();
    chk("t3_fifth_ack", m_arready_o, 4'b0010);
    step(); step();
    drain();

    // Downstream stall: payload stable, no new accepts
    pend[3] = 1; arready_i = 1'b0;
    exp_q.push_back(f_ar(3)); exp_q.push_back(f_ar(0));
    drive_ar(); settle();
    step();
    pend[0] = 1; drive_ar();
    for (int i = 0; i < 10; i++) begin
      chk("t4_arvalid_hold", arvalid_o, 1);
      chk("t4_araddr_hold", araddr_o, f_addr(3));
      chk("t4_no_ack", m_arready_o, 0);
      step();
    end
    arready_i = 1'b1;
    step();
    chk("t4_next_ack", m_arready_o, 4'b0001);
    step(); step();
    drain();

    // R routing, completion and unknown rid
    do_reset();
    pend[2] = 1; arready_i = 1'b1;
    exp_q.push_back(f_ar(2));
    drive_ar(); settle();
    step(); step();
    chk("t5_busy_cnt", idle_o, 0);
    rid_i = 4'd2; rvalid_i = 1'b1; rlast_i = 1'b0; m_rready_i = 4'b0000;
    settle();
    chk("t5_rready_low", rready_o, 0);
    chk("t5_rvalid", m_rvalid_o, 4'b0100);
    m_rready_i = 4'b0100;
    settle();
    chk("t5_rready_high", rready_o, 1);
    step();
    rlast_i = 1'b1;
    settle();
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    settle();
    chk("t5_idle_after_last", idle_o, 1);
    chk("t5_no_err", err_o, 0);
    rid_i = 4'd9; rvalid_i = 1'b1; m_rready_i = '0;
    settle();
    chk("t5_bad_rready", rready_o, 1);
    chk("t5_bad_rvalid", m_rvalid_o, 0);
    step();
    rvalid_i = 1'b0; rid_i = '0;
    step(); step();
    chk("t5_err_sticky", err_o, 1);
    drain();

    // Reset while BUSY with three outstanding on master 0
    do_reset();
    pend[0] = 2; arready_i = 1'b1;
    exp_q.push_back(f_ar(0)); exp_q.push_back(f_ar(0));
    drive_ar(); settle();
    for (int i = 0; i < 4; i++) step();
    arready_i = 1'b0; pend[0] = 1; drive_ar(); settle();
    step();
    chk("t6_busy", arvalid_o, 1);
    chk("t6_not_idle", idle_o, 0);
    rid_i = 4'd9; rvalid_i = 1'b1;
    step();
    rvalid_i = 1'b0; rid_i = '0;
    settle();
    chk("t6_err_set", err_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t6_rst_arvalid", arvalid_o, 0);
    chk("t6_rst_idle", idle_o, 1);
    chk("t6_rst_err", err_o, 0);
    pend[0] = 1; pend[1] = 1; arready_i = 1'b1;
    exp_q.push_back(f_ar(0)); exp_q.push_back(f_ar(1));
    drive_ar(); settle();
    chk("t6_first_grant", m_arready_o, 4'b0001);
    for (int i = 0; i < 4; i++) step();
    drain();

    // Completion with nothing outstanding
    do_reset();
    rid_i = 4'd3; rvalid_i = 1'b1; rlast_i = 1'b1; m_rready_i = 4'b1000;
    settle();
    step();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    settle();
    chk("t7_zero_dec_err", err_o, 1);
    chk("t7_zero_dec_idle", idle_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
